// File: rtl/lsu_issue_sched_pkg.sv
// lsu_sched_pkg: shared constants, FSM state encoding and pointer helpers
// for the LSU issue scheduler.
package lsu_sched_pkg;

   localparam int PTR_W       = 5;   // ring pointer width, MSB is the wrap bit
   localparam int DEP_W       = 4;   // dependency tag width
   localparam int DATA_W      = 32;  // operand width
   localparam int SYNC_STAGES = 2;   // flops on the incoming write pointer

   // Tag value meaning "no producer in flight, read the GRF"
   localparam logic [DEP_W-1:0] NODEP = 4'hF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FENCE = 3'd1,
      REQ   = 3'd2,
      WAIT  = 3'd3,
      ISSUE = 3'd4
   } state_e;

   // Binary to reflected gray code
   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return (b >> 1) ^ b;
   endfunction

endpackage

// File: rtl/lsu_issue_sched_if.sv
// lsu_issue_sched_if: GRF read, bypass read and exe issue handshakes of the
// LSU issue scheduler. master = scheduler side, slave = responder side.
interface lsu_issue_sched_if;
   import lsu_sched_pkg::*;

   // GRF read request / response
   logic              o_grf_valid;
   logic              i_grf_ready;
   logic [4:0]        o_grf_rs1_5;
   logic [4:0]        o_grf_rs2_5;
   logic              o_grf_rd_l;
   logic              o_grf_rd_r;
   logic              i_grf_rsp_valid;
   logic [DATA_W-1:0] i_grf_op_l_32;
   logic [DATA_W-1:0] i_grf_op_r_32;

   // Bypass buffer read request / response
   logic              o_byp_valid;
   logic              i_byp_ready;
   logic [DEP_W-1:0]  o_byp_dep_l_4;
   logic [DEP_W-1:0]  o_byp_dep_r_4;
   logic              o_byp_rd_l;
   logic              o_byp_rd_r;
   logic              i_byp_rsp_valid;
   logic [DATA_W-1:0] i_byp_op_l_32;
   logic [DATA_W-1:0] i_byp_op_r_32;

   // Issue to LSU exe
   logic              o_exe_valid;
   logic              i_exe_ready;
   logic [DATA_W-1:0] o_exe_op_l_32;
   logic [DATA_W-1:0] o_exe_op_r_32;
   logic [PTR_W-2:0]  o_exe_slot_4;

   modport master (
      output o_grf_valid, o_grf_rs1_5, o_grf_rs2_5, o_grf_rd_l, o_grf_rd_r,
      input  i_grf_ready, i_grf_rsp_valid, i_grf_op_l_32, i_grf_op_r_32,
      output o_byp_valid, o_byp_dep_l_4, o_byp_dep_r_4, o_byp_rd_l, o_byp_rd_r,
      input  i_byp_ready, i_byp_rsp_valid, i_byp_op_l_32, i_byp_op_r_32,
      output o_exe_valid, o_exe_op_l_32, o_exe_op_r_32, o_exe_slot_4,
      input  i_exe_ready
   );

   modport slave (
      input  o_grf_valid, o_grf_rs1_5, o_grf_rs2_5, o_grf_rd_l, o_grf_rd_r,
      output i_grf_ready, i_grf_rsp_valid, i_grf_op_l_32, i_grf_op_r_32,
      input  o_byp_valid, o_byp_dep_l_4, o_byp_dep_r_4, o_byp_rd_l, o_byp_rd_r,
      output i_byp_ready, i_byp_rsp_valid, i_byp_op_l_32, i_byp_op_r_32,
      input  o_exe_valid, o_exe_op_l_32, o_exe_op_r_32, o_exe_slot_4,
      output i_exe_ready
   );

endinterface

// File: rtl/lsu_issue_sched_sync.sv
// gray_ptr_sync: multi-flop synchroniser for the dispatch write pointer.
// The pointer is gray coded, so at most one bit changes per update and the
// chain can carry the whole bus safely.
module gray_ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // Shift the foreign-domain pointer through the flop chain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: this array is a flop chain, not a RAM, so resetting every
         // entry is cheap and keeps the post-reset pointer deterministic.
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/lsu_issue_sched.sv
// lsu_issue_sched: walks the 16-slot LSU instruction ring, routes each
// operand fetch to the GRF or bypass buffer, waits for both operands and
// issues the slot to LSU exe.
// Optional build macro LSU_ISSUE_PERF_EN adds saturating stall counters.
module lsu_issue_sched
   import lsu_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [PTR_W-1:0]  i_wr_gray_5,
   output logic [PTR_W-1:0]  o_rd_gray_5,
   output logic              o_lsu_empty,
   output logic [PTR_W-2:0]  o_rd_addr_4,
   input  logic [DEP_W-1:0]  i_dep_l_4,
   input  logic [DEP_W-1:0]  i_dep_r_4,
   input  logic [4:0]        i_rs1_5,
   input  logic [4:0]        i_rs2_5,
   input  logic              i_imm_r,
   input  logic [DATA_W-1:0] i_imm_32,
   input  logic              i_fence,
   input  logic              i_csr_empty,
`ifdef LSU_ISSUE_PERF_EN
   output logic [15:0]       o_stall_fence_16,
   output logic [15:0]       o_stall_op_16,
`endif
   lsu_issue_sched_if.master bus
);

   state_e            state;
   logic [PTR_W-1:0]  wr_sync;
   logic [PTR_W-1:0]  rd_bin, rd_bin_n;
   logic [PTR_W-1:0]  rd_gray, rd_gray_n;
   logic              empty_q;
   logic [DEP_W-1:0]  dep_l, dep_r;
   logic [4:0]        rs1, rs2;
   logic              grf_rd_l, grf_rd_r, byp_rd_l, byp_rd_r;
   logic              grf_pend, byp_pend;
   logic              cap_l, cap_r;
   logic [DATA_W-1:0] op_l, op_r;
   logic              exe_valid;
   logic [PTR_W-2:0]  exe_slot;

   logic              slot_l_grf, slot_r_grf, slot_r_byp;
   logic              grf_need, byp_need, grf_done, byp_done;
   logic              grf_cap_en, byp_cap_en;
   logic              cap_l_set, cap_r_set;
   logic [DATA_W-1:0] op_l_cap, op_r_cap;

   gray_ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (i_wr_gray_5),
      .q    (wr_sync)
   );

   // Routing of the slot presented by instruction storage
   assign slot_l_grf = (i_dep_l_4 == NODEP);
   assign slot_r_grf = !i_imm_r && (i_dep_r_4 == NODEP);
   assign slot_r_byp = !i_imm_r && (i_dep_r_4 != NODEP);

   // Pointer advances only when exe takes the issued slot; empty compares
   // against the post-advance pointer so IDLE never acts on a stale flag.
   assign rd_bin_n  = (state == ISSUE && bus.i_exe_ready) ? rd_bin + 1'b1 : rd_bin;
   assign rd_gray_n = bin2gray(rd_bin_n);

   assign grf_need = grf_rd_l || grf_rd_r;
   assign byp_need = byp_rd_l || byp_rd_r;
   assign grf_done = !grf_pend || bus.i_grf_ready;
   assign byp_done = !byp_pend || bus.i_byp_ready;
   assign op_l_cap = grf_rd_l ? bus.i_grf_op_l_32 : bus.i_byp_op_l_32;
   assign op_r_cap = grf_rd_r ? bus.i_grf_op_r_32 : bus.i_byp_op_r_32;

   // Capture enables: a source may respond once its request is accepted,
   // including the acceptance cycle itself; anything else is dropped.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      grf_cap_en = 1'b0;
      byp_cap_en = 1'b0;
      if (state == WAIT) begin
         grf_cap_en = 1'b1;
         byp_cap_en = 1'b1;
      end else if (state == REQ) begin
         grf_cap_en = grf_need && grf_done;
         byp_cap_en = byp_need && byp_done;
      end
      cap_l_set = !cap_l &&
                  ((grf_rd_l && grf_cap_en && bus.i_grf_rsp_valid) ||
                   (byp_rd_l && byp_cap_en && bus.i_byp_rsp_valid));
      cap_r_set = !cap_r &&
                  ((grf_rd_r && grf_cap_en && bus.i_grf_rsp_valid) ||
                   (byp_rd_r && byp_cap_en && bus.i_byp_rsp_valid));
   end

   // Scheduler FSM: slot latch, fence hold, request handshakes, capture, issue
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rd_bin    <= '0;
         rd_gray   <= '0;
         empty_q   <= 1'b1;
         dep_l     <= '0;
         dep_r     <= '0;
         rs1       <= '0;
         rs2       <= '0;
         grf_rd_l  <= 1'b0;
         grf_rd_r  <= 1'b0;
         byp_rd_l  <= 1'b0;
         byp_rd_r  <= 1'b0;
         grf_pend  <= 1'b0;
         byp_pend  <= 1'b0;
         cap_l     <= 1'b0;
         cap_r     <= 1'b0;
         op_l      <= '0;
         op_r      <= '0;
         exe_valid <= 1'b0;
         exe_slot  <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         empty_q <= (wr_sync == rd_gray_n);
         rd_bin  <= rd_bin_n;
         rd_gray <= rd_gray_n;

         if (cap_l_set) begin
            cap_l <= 1'b1;
            op_l  <= op_l_cap;
         end
         if (cap_r_set) begin
            cap_r <= 1'b1;
            op_r  <= op_r_cap;
         end

         unique case (state)
            IDLE: if (!empty_q) begin
               dep_l    <= i_dep_l_4;
               dep_r    <= i_dep_r_4;
               rs1      <= i_rs1_5;
               rs2      <= i_rs2_5;
               grf_rd_l <= slot_l_grf;
               grf_rd_r <= slot_r_grf;
               byp_rd_l <= !slot_l_grf;
               byp_rd_r <= slot_r_byp;
               cap_l    <= 1'b0;
               cap_r    <= i_imm_r;
               op_l     <= '0;
               op_r     <= i_imm_r ? i_imm_32 : '0;
               exe_slot <= rd_bin[PTR_W-2:0];
               if (i_fence) begin
                  state <= FENCE;
               end else begin
                  state    <= REQ;
                  grf_pend <= slot_l_grf || slot_r_grf;
                  byp_pend <= !slot_l_grf || slot_r_byp;
               end
            end
            FENCE: if (i_csr_empty) begin
               state    <= REQ;
               grf_pend <= grf_need;
               byp_pend <= byp_need;
            end
            REQ: begin
               if (bus.i_grf_ready) grf_pend <= 1'b0;
               if (bus.i_byp_ready) byp_pend <= 1'b0;
               if (grf_done && byp_done) state <= WAIT;
            end
            WAIT: if ((cap_l || cap_l_set) && (cap_r || cap_r_set)) begin
               state     <= ISSUE;
               exe_valid <= 1'b1;
            end
            ISSUE: if (bus.i_exe_ready) begin
               state     <= IDLE;
               exe_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LSU_ISSUE_PERF_EN
   logic [15:0] stall_fence, stall_op;

   // Saturating counts of cycles spent waiting on CSR drain and operands
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_fence <= '0;
         stall_op    <= '0;
      end else begin
         if (state == FENCE && stall_fence != 16'hFFFF) stall_fence <= stall_fence + 1'b1;
         if (state == WAIT  && stall_op    != 16'hFFFF) stall_op    <= stall_op + 1'b1;
      end
   end

   assign o_stall_fence_16 = stall_fence;
   assign o_stall_op_16    = stall_op;
`endif

   assign o_rd_gray_5       = rd_gray;
   assign o_lsu_empty       = empty_q;
   assign o_rd_addr_4       = rd_bin[PTR_W-2:0];

   assign bus.o_grf_valid   = grf_pend;
   assign bus.o_grf_rs1_5   = rs1;
   assign bus.o_grf_rs2_5   = rs2;
   assign bus.o_grf_rd_l    = grf_rd_l;
   assign bus.o_grf_rd_r    = grf_rd_r;
   assign bus.o_byp_valid   = byp_pend;
   assign bus.o_byp_dep_l_4 = dep_l;
   assign bus.o_byp_dep_r_4 = dep_r;
   assign bus.o_byp_rd_l    = byp_rd_l;
   assign bus.o_byp_rd_r    = byp_rd_r;
   assign bus.o_exe_valid   = exe_valid;
   assign bus.o_exe_op_l_32 = op_l;
   assign bus.o_exe_op_r_32 = op_r;
   assign bus.o_exe_slot_4  = exe_slot;

endmodule
